// File: rtl/uart_tx_serializer_if.sv
// Byte-wide valid/ready handshake into the UART transmitter.
// The producer uses the master modport; the transmitter uses the slave modport.
interface uart_tx_serializer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Buffered 8N1 UART transmitter: small byte FIFO feeding an LSB-first serial
// framer with a registered, idle-high line output.
// Optional feature macro: UART_TX_PARITY_EN adds one parity bit after the data
// bits (even parity, or odd parity when PARITY_ODD = 1).
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 SYSCLK,
    input  logic                 SYSRESET,
    uart_tx_serializer_if.slave  tx_if,
    output logic                 UART_TXD,
    output logic                 tx_busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    localparam logic ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             push;
    logic             pop;
    logic [7:0]       rd_data;

    // Framer state
    state_t            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic              stop_q;
    logic [7:0]        shift_q;
    logic              txd_q;
    logic              baud_last;
`ifdef UART_TX_PARITY_EN
    logic              par_q;
`endif

    assign tx_if.tx_ready = (count_q != FULL_CNT);
    assign push           = tx_if.tx_valid & tx_if.tx_ready;
    assign rd_data        = mem_q[rd_ptr_q];
    assign baud_last      = (baud_q == BAUD_LAST);

    assign UART_TXD = txd_q;
    assign tx_busy  = (state_q != S_IDLE) || (count_q != '0);

    // Pop when idle, or at the very end of the last stop bit so the next
    // start bit follows with no idle gap; occupancy follows push/pop.
    always_comb begin
        pop = 1'b0;
        if (count_q != '0) begin
            if (state_q == S_IDLE) begin
                pop = 1'b1;
            end else if ((state_q == S_STOP) && baud_last && (stop_q == STOP_LAST)) begin
                pop = 1'b1;
            end
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    // FIFO pointers and occupancy; reset flushes any queued bytes.
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // FIFO data storage; contents are don't-care until written.
    always_ff @(posedge SYSCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_if.tx_data;
        end
    end

    // Frame sequencer: the line level is registered and updated on the same
    // edge as the state transition that defines it.
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q <= rd_data;
`ifdef UART_TX_PARITY_EN
                        par_q   <= (^rd_data) ^ ODD_BIT;
`endif
                        baud_q  <= '0;
                        txd_q   <= 1'b0;
                        state_q <= S_START;
                    end
                end

                S_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd_q   <= par_q;
                            state_q <= S_PARITY;
`else
                            txd_q   <= 1'b1;
                            stop_q  <= 1'b0;
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        txd_q   <= 1'b1;
                        stop_q  <= 1'b0;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (stop_q == STOP_LAST) begin
                            if (pop) begin
                                shift_q <= rd_data;
`ifdef UART_TX_PARITY_EN
                                par_q   <= (^rd_data) ^ ODD_BIT;
`endif
                                txd_q   <= 1'b0;
                                state_q <= S_START;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

                default: begin
                    baud_q  <= '0;
                    txd_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomised bench for uart_tx_serializer against a waveform-level reference:
// each byte leaving the model FIFO expands into its expected per-cycle line
// levels, and the line, tx_ready and tx_busy are compared every cycle.
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int STOP  = 1;
    localparam int ODD   = 0;

    logic SYSCLK = 1'b0;
    logic SYSRESET;
    logic UART_TXD;
    logic tx_busy;

    uart_tx_serializer_if tx_if ();

    uart_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .STOP_BITS    (STOP),
        .PARITY_ODD   (ODD)
    ) dut (
        .SYSCLK   (SYSCLK),
        .SYSRESET (SYSRESET),
        .tx_if    (tx_if),
        .UART_TXD (UART_TXD),
        .tx_busy  (tx_busy)
    );

    always #5 SYSCLK = ~SYSCLK;

    int checks = 0;
    int errors = 0;
    int dut_acc = 0;

    // Reference: bytes waiting to be framed, and expected future line levels
    // (entry 0 is the level for the cycle following the most recent edge).
    logic [7:0] fifo_q [$];
    bit         line_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void append_frame(input logic [7:0] b);
        bit bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back((^b) ^ (ODD != 0));
`endif
        for (int s = 0; s < STOP; s++) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < CPB; c++) line_q.push_back(bits[k]);
        end
    endfunction

    // One clock cycle: drive inputs, advance DUT and model, compare outputs.
    task automatic step(input logic valid, input logic [7:0] data, input logic rst);
        bit push;
        tx_if.tx_valid = valid;
        tx_if.tx_data  = data;
        SYSRESET       = rst;
        push = valid && !rst && (fifo_q.size() != DEPTH);
        if (valid && !rst && tx_if.tx_ready) dut_acc++;
        @(posedge SYSCLK);
        if (rst) begin
            line_q.delete();
            fifo_q.delete();
        end else begin
            if (line_q.size() != 0) void'(line_q.pop_front());
            if (line_q.size() == 0 && fifo_q.size() != 0) append_frame(fifo_q.pop_front());
            if (push) fifo_q.push_back(data);
        end
        #1;
        chk("txd",   UART_TXD,       (line_q.size() != 0) ? line_q[0] : 1'b1);
        chk("ready", tx_if.tx_ready, fifo_q.size() != DEPTH);
        chk("busy",  tx_busy,        (line_q.size() != 0) || (fifo_q.size() != 0));
    endtask

    task automatic drain();
        int n = 0;
        while ((tx_busy || line_q.size() != 0 || fifo_q.size() != 0) && n < 2000) begin
            step(1'b0, 8'($urandom), 1'b0);
            n++;
        end
        chk("drain_timeout", n < 2000, 1);
    endtask

    initial begin
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        SYSRESET       = 1'b1;

        // Reset then idle: line high, ready high, not busy.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'($urandom), 1'b0);
            chk("idle_txd", UART_TXD, 1);
            chk("idle_busy", tx_busy, 0);
        end

        // Single byte 0x55 with literal waveform expectations.
        step(1'b1, 8'h55, 1'b0);
`ifndef UART_TX_PARITY_EN
        for (int k = 0; k < 10 * CPB; k++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("p55_bit", UART_TXD, (k / CPB) % 2);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("p55_busy_fall", tx_busy, 0);
`else
        drain();
        // Parity frame for 0x07: 11 bit times, parity bit is bit index 9.
        step(1'b1, 8'h07, 1'b0);
        for (int k = 0; k < 11 * CPB; k++) begin
            step(1'b0, 8'h00, 1'b0);
            if (k / CPB == 9) chk("par07_bit", UART_TXD, (ODD != 0) ? 0 : 1);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("par07_busy_fall", tx_busy, 0);
`endif
        drain();

        // Hold valid for 8 cycles from idle: exactly 5 bytes fit.
        dut_acc = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 1), 1'b0);
        chk("hold_accepts", dut_acc, 5);
        drain();

        // Reset during the data bits of 0xA3 with two bytes queued.
        step(1'b1, 8'hA3, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0);
        chk("pre_rst_busy", tx_busy, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("rst_txd", UART_TXD, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ready", tx_if.tx_ready, 1);
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 8'($urandom), 1'b0);
            chk("post_rst_txd", UART_TXD, 1);
        end

        // Randomised traffic with bursts, gaps and rare resets.
        for (int i = 0; i < 3000; i++) begin
            logic v;
            v = ((i / 200) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            step(v, 8'($urandom), ($urandom_range(0, 499) == 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
